// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: ID-stage data hazards, cache-miss stall FSM,
// miss watchdog and saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int unsigned            REG_W    = 4,
  parameter int unsigned            OPC_W    = 4,
  parameter int unsigned            FLAG_W   = 3,
  parameter logic [OPC_W-1:0]       B_OPC    = 4'hC,
  parameter logic [OPC_W-1:0]       BR_OPC   = 4'hD,
  parameter logic [2:0]             UNCOND   = 3'b111,
  parameter bit                     ZERO_REG = 1'b1,
  parameter int unsigned            WDOG_W   = 8,
  parameter int unsigned            CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPC_W-1:0]  ifid_opcode,
  input  logic [REG_W-1:0]  ifid_rs,
  input  logic [REG_W-1:0]  ifid_rt,
  input  logic [REG_W-1:0]  idex_rd,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic              exmem_regwrite,
  input  logic [FLAG_W-1:0] idex_flag_en,
  input  logic [2:0]        condition,
  input  logic              branch_taken,
  input  logic              imiss,
  input  logic              dmiss,
  input  logic              ifill_done,
  input  logic              dfill_done,
  input  logic              perf_clr,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              ctrl_bubble,
  output logic              pipe_freeze,
  output logic              wdog_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DMISS, S_IMISS} state_e;

  state_e              state_q, state_d, eff_state;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                wdog_err_q, wdog_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                h_ld, h_fl, h_br, haz;
  logic                is_b, is_br;

  function automatic logic match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && !(ZERO_REG && (b == '0));
  endfunction

  always_comb begin
    is_b  = (ifid_opcode == B_OPC);
    is_br = (ifid_opcode == BR_OPC);
    h_ld  = idex_memread && (match(ifid_rs, idex_rd) || match(ifid_rt, idex_rd));
    h_fl  = (is_b || is_br) && (|idex_flag_en) && (condition != UNCOND);
    h_br  = is_br && ((idex_regwrite && match(ifid_rs, idex_rd)) ||
                      (exmem_regwrite && match(ifid_rs, exmem_rd)));
    haz   = h_ld || h_fl || h_br;
  end

  // Outputs follow the state being entered this cycle (Mealy entry); exits are registered.
  always_comb begin
    eff_state = state_q;
    if (state_q == S_RUN) begin
      if (dmiss)      eff_state = S_DMISS;
      else if (imiss) eff_state = S_IMISS;
    end else if (state_q == S_IMISS && dmiss) begin
      eff_state = S_DMISS;
    end
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    ctrl_bubble   = 1'b0;
    pipe_freeze   = 1'b0;
    if (rst_n) begin
      unique case (eff_state)
        S_DMISS: begin
          pipe_freeze   = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end
        S_IMISS: begin
          pc_write_en = 1'b0;
          ifid_flush  = 1'b1;
        end
        default: begin
          if (haz) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            ctrl_bubble   = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (dmiss)      state_d = S_DMISS;
        else if (imiss) state_d = S_IMISS;
      end
      S_DMISS: begin
        if (dfill_done) state_d = imiss ? S_IMISS : S_RUN;
      end
      S_IMISS: begin
        if (dmiss)           state_d = S_DMISS;
        else if (ifill_done) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q)
      wdog_d = '0;
    else if (state_q != S_RUN && wdog_q != '1)
      wdog_d = wdog_q + 1'b1;
    wdog_err_d = wdog_err_q || (wdog_d == '1);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (ifid_flush && flush_cnt_q != '1)   flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wdog_q      <= '0;
      wdog_err_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      wdog_err_q  <= wdog_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign wdog_err  = wdog_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
